memory_controller: RTL and testbench

//  - Dual-port memory controller in front of an on-chip word-addressed RAM.
//  - Independent write and read request ports; each accepts one request per clock, with no backpressure.
//  - Each request returns a one-cycle acknowledge, tagged with the request address, after a fixed pipeline latency.
//  - Serves as the memory model used by the simulator top level.

---
 rtl/memory_controller.sv | 158 +++++++++++++++
 tb/tb_memory_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// -----------------------------------------------------------------------------
// memory_controller
//
// Dual-port controller in front of an on-chip, word-addressed RAM. The write
// and read ports each accept one request per clock with no backpressure. Every
// accepted request produces a one-cycle acknowledge, tagged with the full
// request address, after a fixed pipeline latency (WR_LATENCY / RD_LATENCY).
// Returned address/data registers hold their last value while the ack is low.
//
// Storage index is address[DEPTH_LOG2-1:0]; upper address bits alias onto
// the same word but are kept intact on the returned address.
//
// Optional feature macro: MC_BYPASS_EN
//   undefined (default): a same-cycle read and write to one index is
//                        read-first (the read returns the old word).
//   defined            : write-first; the read returns that cycle's wr_data.
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   rst_n           in   asynchronous active-low reset (RAM not affected)
//   wr_address      in   write address
//   wr_en           in   write request
//   wr_data         in   write data
//   wr_ret_address  out  address of the write being acknowledged
//   wr_ret_ack      out  write-complete pulse
//   rd_address      in   read address
//   rd_en           in   read request
//   rd_ret_data     out  read data
//   rd_ret_address  out  address of the read being returned
//   rd_ret_ack      out  read-data-valid pulse
// -----------------------------------------------------------------------------
module memory_controller #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int RD_LATENCY = 4,
   parameter int WR_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] wr_address,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] wr_ret_address,
   output logic              wr_ret_ack,
   input  logic [ADDR_W-1:0] rd_address,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_ret_data,
   output logic [ADDR_W-1:0] rd_ret_address,
   output logic              rd_ret_ack
);

   localparam int WORDS = 1 << DEPTH_LOG2;

   // RAM starts all-zero; reset never touches it.
   logic [DATA_W-1:0] mem [WORDS] = '{default: '0};

   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DATA_W-1:0]     rd_word;

   assign wr_idx = wr_address[DEPTH_LOG2-1:0];
   assign rd_idx = rd_address[DEPTH_LOG2-1:0];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

`ifdef MC_BYPASS_EN
   // Write-first: forward the word being written this cycle.
   assign rd_word = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
`else
   // Read-first: the RAM update lands at the same edge, so the old word is seen.
   assign rd_word = mem[rd_idx];
`endif

   // ---- stage p0 .. p(N-1): valid shift chains (control, reset) ----
   logic [WR_LATENCY-1:0] wr_vld_p;
   logic [RD_LATENCY-1:0] rd_vld_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_vld_p <= '0;
         rd_vld_p <= '0;
      end else begin
         wr_vld_p[0] <= wr_en;
         for (int k = 1; k < WR_LATENCY; k++) wr_vld_p[k] <= wr_vld_p[k-1];
         rd_vld_p[0] <= rd_en;
         for (int k = 1; k < RD_LATENCY; k++) rd_vld_p[k] <= rd_vld_p[k-1];
      end
   end

   // ---- intermediate data stages (no reset; loaded only with a valid entry) ----
   logic              wr_last_vld;
   logic [ADDR_W-1:0] wr_last_addr;
   logic              rd_last_vld;
   logic [ADDR_W-1:0] rd_last_addr;
   logic [DATA_W-1:0] rd_last_data;

   generate
      if (WR_LATENCY > 1) begin : g_wr_pipe
         logic [ADDR_W-1:0] addr_p [WR_LATENCY-1];
         always_ff @(posedge clk) begin
            if (wr_en) addr_p[0] <= wr_address;
            for (int k = 1; k < WR_LATENCY-1; k++)
               if (wr_vld_p[k-1]) addr_p[k] <= addr_p[k-1];
         end
         assign wr_last_vld  = wr_vld_p[WR_LATENCY-2];
         assign wr_last_addr = addr_p[WR_LATENCY-2];
      end else begin : g_wr_direct
         assign wr_last_vld  = wr_en;
         assign wr_last_addr = wr_address;
      end

      if (RD_LATENCY > 1) begin : g_rd_pipe
         logic [ADDR_W-1:0] addr_p [RD_LATENCY-1];
         logic [DATA_W-1:0] data_p [RD_LATENCY-1];
         always_ff @(posedge clk) begin
            if (rd_en) begin
               addr_p[0] <= rd_address;
               data_p[0] <= rd_word;
            end
            for (int k = 1; k < RD_LATENCY-1; k++) begin
               if (rd_vld_p[k-1]) begin
                  addr_p[k] <= addr_p[k-1];
                  data_p[k] <= data_p[k-1];
               end
            end
         end
         assign rd_last_vld  = rd_vld_p[RD_LATENCY-2];
         assign rd_last_addr = addr_p[RD_LATENCY-2];
         assign rd_last_data = data_p[RD_LATENCY-2];
      end else begin : g_rd_direct
         assign rd_last_vld  = rd_en;
         assign rd_last_addr = rd_address;
         assign rd_last_data = rd_word;
      end
   endgenerate

   // ---- output stage: loads only on a valid entry so values hold between acks ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ret_address <= '0;
         rd_ret_address <= '0;
         rd_ret_data    <= '0;
      end else begin
         if (wr_last_vld) wr_ret_address <= wr_last_addr;
         if (rd_last_vld) begin
            rd_ret_address <= rd_last_addr;
            rd_ret_data    <= rd_last_data;
         end
      end
   end

   assign wr_ret_ack = wr_vld_p[WR_LATENCY-1];
   assign rd_ret_ack = rd_vld_p[RD_LATENCY-1];

endmodule

// File: tb/tb_memory_controller.sv
`timescale 1ns/1ps
module tb_memory_controller;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int DL  = 10;
   localparam int RDL = 4;
   localparam int WRL = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b1;
   logic [AW-1:0] wr_address = '0, rd_address = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [AW-1:0] wr_ret_address, rd_ret_address;
   logic [DW-1:0] rd_ret_data;
   logic          wr_ret_ack, rd_ret_ack;

   memory_controller #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL),
                       .RD_LATENCY(RDL), .WR_LATENCY(WRL)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
      .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
      .rd_address(rd_address), .rd_en(rd_en),
      .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack));

   // Latency-sweep instances share one small stimulus.
   logic          l_wr_en = 1'b0, l_rd_en = 1'b0;
   logic [AW-1:0] l_addr = '0;
   logic [DW-1:0] l_data = '0;
   logic [AW-1:0] la_wr_ret_address, la_rd_ret_address, lb_wr_ret_address, lb_rd_ret_address;
   logic [DW-1:0] la_rd_ret_data, lb_rd_ret_data;
   logic          la_wr_ret_ack, la_rd_ret_ack, lb_wr_ret_ack, lb_rd_ret_ack;

   memory_controller #(.RD_LATENCY(1), .WR_LATENCY(1)) u_lat_a (
      .clk(clk), .rst_n(rst_n),
      .wr_address(l_addr), .wr_en(l_wr_en), .wr_data(l_data),
      .wr_ret_address(la_wr_ret_address), .wr_ret_ack(la_wr_ret_ack),
      .rd_address(l_addr), .rd_en(l_rd_en),
      .rd_ret_data(la_rd_ret_data), .rd_ret_address(la_rd_ret_address), .rd_ret_ack(la_rd_ret_ack));

   memory_controller #(.RD_LATENCY(16), .WR_LATENCY(1)) u_lat_b (
      .clk(clk), .rst_n(rst_n),
      .wr_address(l_addr), .wr_en(l_wr_en), .wr_data(l_data),
      .wr_ret_address(lb_wr_ret_address), .wr_ret_ack(lb_wr_ret_ack),
      .rd_address(l_addr), .rd_en(l_rd_en),
      .rd_ret_data(lb_rd_ret_data), .rd_ret_address(lb_rd_ret_address), .rd_ret_ack(lb_rd_ret_ack));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: word array plus queues of expected responses with due cycle.
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          wr_q[$];
   exp_t          rd_q[$];
   logic [DW-1:0] ref_mem [1 << DL];

   // Called at posedge+1; the request is accepted at the next edge.
   task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic re, input logic [AW-1:0] ra);
      exp_t e;
      wr_en = we; wr_address = wa; wr_data = wd;
      rd_en = re; rd_address = ra;
      if (re) begin
         e.addr = ra;
         e.data = ref_mem[ra[DL-1:0]];
`ifdef MC_BYPASS_EN
         if (we && (wa[DL-1:0] == ra[DL-1:0])) e.data = wd;
`endif
         e.due = cyc + RDL;
         rd_q.push_back(e);
      end
      if (we) begin
         e.addr = wa;
         e.data = '0;
         e.due  = cyc + WRL;
         wr_q.push_back(e);
         ref_mem[wa[DL-1:0]] = wd;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         wr_en = 1'b0; rd_en = 1'b0;
         wr_address = AW'($urandom); rd_address = AW'($urandom); wr_data = DW'($urandom);
         @(posedge clk); #1;
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT acknowledges.
   initial begin
      exp_t          e;
      logic [AW-1:0] last_wa, last_ra;
      logic [DW-1:0] last_rd;
      last_wa = '0; last_ra = '0; last_rd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_wr_ack", wr_ret_ack, 0);
            check("rst_rd_ack", rd_ret_ack, 0);
            check("rst_wr_addr", wr_ret_address, 0);
            check("rst_rd_addr", rd_ret_address, 0);
            check("rst_rd_data", rd_ret_data, 0);
            last_wa = '0; last_ra = '0; last_rd = '0;
         end else begin
            if (wr_ret_ack) begin
               if (wr_q.size() == 0) check("wr_unexpected_ack", wr_ret_ack, 0);
               else begin
                  e = wr_q.pop_front();
                  check("wr_addr", wr_ret_address, e.addr);
                  check("wr_ack_cycle", cyc, e.due);
               end
               last_wa = wr_ret_address;
            end else check("wr_addr_hold", wr_ret_address, last_wa);
            if (rd_ret_ack) begin
               if (rd_q.size() == 0) check("rd_unexpected_ack", rd_ret_ack, 0);
               else begin
                  e = rd_q.pop_front();
                  check("rd_addr", rd_ret_address, e.addr);
                  check("rd_data", rd_ret_data, e.data);
                  check("rd_ack_cycle", cyc, e.due);
               end
               last_ra = rd_ret_address;
               last_rd = rd_ret_data;
            end else begin
               check("rd_addr_hold", rd_ret_address, last_ra);
               check("rd_data_hold", rd_ret_data, last_rd);
            end
         end
      end
   end

   initial begin
      int            t0, wa_lat, wb_lat, ra_lat, rb_lat, rb_cnt;
      logic [AW-1:0] a, b;
      logic [DW-1:0] ra_data, rb_data;
      for (int i = 0; i < (1 << DL); i++) ref_mem[i] = '0;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Stream: both ports every cycle, addresses and data counting together.
      for (int i = 0; i < 8; i++) op(1'b1, AW'(i), DW'(i), 1'b1, AW'(i));
      idle(8);

      // Single write then read of 0x0005.
      op(1'b1, 16'h0005, 16'hA5A5, 1'b0, '0);
      idle(3);
      op(1'b0, '0, '0, 1'b1, 16'h0005);
      idle(6);

      // Alias: upper bits ignored for storage, kept on the returned address.
      op(1'b1, 16'h0403, 16'h1234, 1'b0, '0);
      idle(2);
      op(1'b0, '0, '0, 1'b1, 16'h0003);
      idle(6);

      // Idle with garbage on inputs, then read back earlier words.
      idle(20);
      for (int i = 0; i < 8; i++) op(1'b0, '0, '0, 1'b1, AW'(i) | 16'hFC00);
      idle(6);

      // Random traffic over a small index range to force collisions.
      for (int i = 0; i < 300; i++) begin
         a = {6'($urandom), 10'($urandom_range(0, 15))};
         b = {6'($urandom), 10'($urandom_range(0, 15))};
         op(1'($urandom), a, DW'($urandom), 1'($urandom), b);
      end
      idle(10);

      // Reset mid-flight: three reads, then reset before any of them returns.
      op(1'b0, '0, '0, 1'b1, 16'h0001);
      op(1'b0, '0, '0, 1'b1, 16'h0002);
      op(1'b0, '0, '0, 1'b1, 16'h0003);
      rd_en = 1'b0;
      rst_n = 1'b0;
      wr_q.delete();
      rd_q.delete();
      #1;
      check("midrst_rd_ack", rd_ret_ack, 0);
      check("midrst_wr_ack", wr_ret_ack, 0);
      check("midrst_rd_addr", rd_ret_address, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(20);

      // Traffic after reset; RAM kept its contents.
      for (int i = 0; i < 40; i++) begin
         a = {6'($urandom), 10'($urandom_range(0, 15))};
         op(1'($urandom), a, DW'($urandom), 1'b1, a ^ 16'h0001);
      end
      idle(25);
      check("wr_q_drained", wr_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);

      // Latency sweep on the extra instances.
      l_wr_en = 1'b1; l_addr = 16'h0021; l_data = 16'h5A5A; t0 = cyc;
      @(posedge clk); #1 l_wr_en = 1'b0;
      wa_lat = -1; wb_lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (la_wr_ret_ack && wa_lat < 0) wa_lat = cyc - t0;
         if (lb_wr_ret_ack && wb_lat < 0) wb_lat = cyc - t0;
      end
      check("lat_a_wr_cycles", wa_lat, 1);
      check("lat_b_wr_cycles", wb_lat, 1);
      check("lat_a_wr_addr", la_wr_ret_address, 16'h0021);
      check("lat_b_wr_addr", lb_wr_ret_address, 16'h0021);

      @(posedge clk); #1;
      l_rd_en = 1'b1; t0 = cyc;
      @(posedge clk); #1 l_rd_en = 1'b0;
      ra_lat = -1; rb_lat = -1; rb_cnt = 0; ra_data = '0; rb_data = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (la_rd_ret_ack && ra_lat < 0) begin ra_lat = cyc - t0; ra_data = la_rd_ret_data; end
         if (lb_rd_ret_ack) begin
            rb_cnt++;
            if (rb_lat < 0) begin rb_lat = cyc - t0; rb_data = lb_rd_ret_data; end
         end
      end
      check("lat_a_rd_cycles", ra_lat, 1);
      check("lat_b_rd_cycles", rb_lat, 16);
      check("lat_b_rd_pulses", rb_cnt, 1);
      check("lat_a_rd_data", ra_data, 16'h5A5A);
      check("lat_b_rd_data", rb_data, 16'h5A5A);
      check("lat_b_rd_addr", lb_rd_ret_address, 16'h0021);
      check("lat_a_rd_addr", la_rd_ret_address, 16'h0021);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
